// File: rtl/axi_native_slave_pkg.sv
// Shared encodings for the AXI-to-native bridge: burst and response codes,
// FSM state encoding and a helper that flags unsupported burst types.
package axi_native_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BEAT,
    ST_WR_MEM,
    ST_WR_RESP,
    ST_RD_MEM,
    ST_RD_BEAT
  } state_e;

  // WRAP is not supported by this endpoint and 2'b11 is reserved by AXI.
  function automatic logic burst_unsupported(input logic [1:0] burst);
    return (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address generator for AXI bursts. INCR steps by the beat size and
// wraps modulo 2^ADDR_W; FIXED (and any unsupported type) holds the address.
module axi_burst_addr
  import axi_native_slave_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;

  assign step = ADDR_W'(1) << size;

  // Select the stepped or held address depending on burst type.
  always_comb begin
    // NOTE: assigning a default first means every path drives next_addr, so
    // no latch is inferred when a new burst type is added later.
    next_addr = addr;
    if (burst == BURST_INCR) next_addr = addr + step;
  end

endmodule

// File: rtl/axi_native_slave.sv
// AXI4 subordinate that accepts one burst at a time and replays each beat as a
// single native memory access (valid/address/wdata/wstrb -> ready/rdata).
// Unsupported bursts and oversize beats are answered with SLVERR without
// touching memory; the beat count, not wlast, decides how many W beats land.
module axi_native_slave
  import axi_native_slave_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  // write address channel
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [LEN_W-1:0]    s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  // write data channel
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  // write response channel
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  // read address channel
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [LEN_W-1:0]    s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  // read data channel
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  // native memory side
  output logic                valid,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int MAX_SIZE = $clog2(STRB_W);

  state_e            state;
  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  count;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic              prio_w;    // 1: write wins the next AW/AR collision

  logic              grant_w;
  logic              last_beat;
  logic              wlast_bad;
  logic [ADDR_W-1:0] next_addr;

  logic [ID_W-1:0]   sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [2:0]        sel_size;
  logic [1:0]        sel_burst;
  logic              sel_err;

  // A lone request is always granted; on a collision the flag decides and
  // flips so that successive collisions alternate between the channels.
  assign grant_w       = s_axi_awvalid && (!s_axi_arvalid || prio_w);
  assign s_axi_awready = (state == ST_IDLE) && s_axi_awvalid && grant_w;
  assign s_axi_arready = (state == ST_IDLE) && s_axi_arvalid && !grant_w;

  assign last_beat = (count == '0);
  assign wlast_bad = (s_axi_wlast != last_beat);
  assign sel_err   = burst_unsupported(sel_burst) || (int'(sel_size) > MAX_SIZE);

  // Route the granted channel's request fields to the latch point.
  always_comb begin
    if (grant_w) begin
      sel_id    = s_axi_awid;
      sel_addr  = s_axi_awaddr;
      sel_len   = s_axi_awlen;
      sel_size  = s_axi_awsize;
      sel_burst = s_axi_awburst;
    end else begin
      sel_id    = s_axi_arid;
      sel_addr  = s_axi_araddr;
      sel_len   = s_axi_arlen;
      sel_size  = s_axi_arsize;
      sel_burst = s_axi_arburst;
    end
  end

  axi_burst_addr #(
    .ADDR_W (ADDR_W)
  ) u_burst_addr (
    .addr      (address),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Transaction FSM; every AXI response and native request output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      id_q         <= '0;
      count        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      err_q        <= 1'b0;
      prio_w       <= 1'b1;
      s_axi_wready <= 1'b0;
      s_axi_bid    <= '0;
      s_axi_bresp  <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_rid    <= '0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= '0;
      s_axi_rlast  <= 1'b0;
      s_axi_rvalid <= 1'b0;
      valid        <= 1'b0;
      address      <= '0;
      wdata        <= '0;
      wstrb        <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of its peers, independent of statement order.
      case (state)
        ST_IDLE: begin
          if (s_axi_awready || s_axi_arready) begin
            id_q    <= sel_id;
            address <= sel_addr;
            count   <= sel_len;
            size_q  <= sel_size;
            burst_q <= sel_burst;
            err_q   <= sel_err;
            if (s_axi_awvalid && s_axi_arvalid) prio_w <= !grant_w;
            if (grant_w) begin
              s_axi_wready <= 1'b1;
              state        <= ST_WR_BEAT;
            end else begin
              valid <= !sel_err;
              wstrb <= '0;
              state <= ST_RD_MEM;
            end
          end
        end

        ST_WR_BEAT: begin
          if (s_axi_wvalid) begin
            wdata <= s_axi_wdata;
            wstrb <= s_axi_wstrb;
            if (err_q || wlast_bad) begin
              // Errored burst: swallow the beat without a memory access.
              err_q <= 1'b1;
              if (last_beat) begin
                s_axi_wready <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bid    <= id_q;
                s_axi_bresp  <= RESP_SLVERR;
                state        <= ST_WR_RESP;
              end else begin
                address <= next_addr;
                count   <= count - LEN_W'(1);
              end
            end else begin
              s_axi_wready <= 1'b0;
              valid        <= 1'b1;
              state        <= ST_WR_MEM;
            end
          end
        end

        ST_WR_MEM: begin
          if (ready) begin
            valid <= 1'b0;
            if (last_beat) begin
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= id_q;
              s_axi_bresp  <= err_q ? RESP_SLVERR : RESP_OKAY;
              state        <= ST_WR_RESP;
            end else begin
              address      <= next_addr;
              count        <= count - LEN_W'(1);
              s_axi_wready <= 1'b1;
              state        <= ST_WR_BEAT;
            end
          end
        end

        ST_WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end

        ST_RD_MEM: begin
          // Errored reads complete at once with zero data.
          if (err_q || ready) begin
            valid        <= 1'b0;
            s_axi_rdata  <= err_q ? '0 : rdata;
            s_axi_rresp  <= err_q ? RESP_SLVERR : RESP_OKAY;
            s_axi_rid    <= id_q;
            s_axi_rlast  <= last_beat;
            s_axi_rvalid <= 1'b1;
            state        <= ST_RD_BEAT;
          end
        end

        ST_RD_BEAT: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            if (last_beat) begin
              state <= ST_IDLE;
            end else begin
              address <= next_addr;
              count   <= count - LEN_W'(1);
              valid   <= !err_q;
              state   <= ST_RD_MEM;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_native_slave.md
Name: axi_native_slave

Overview:
- AXI4 subordinate (slave) that accepts burst transactions from an AXI4 master, such as the DMA engines, and replays them as single-beat native memory accesses.
- Native side uses valid/address/wdata/wstrb/rdata/ready and fronts on-chip RAM or peripherals.
- One transaction in flight at a time; reads and writes are arbitrated.
- Intended as the bench target and SoC memory endpoint for DMA traffic.

Parameters:
- ADDR_W, 32, AXI and native address width.
- DATA_W, 32, data width; must be 32 or 64.
- ID_W, 1, AXI ID width.
- LEN_W, 8, AXI burst length field width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/LEN_W/3/2  write address channel.
- s_axi_awvalid  in  1; s_axi_awready  out  1.
- s_axi_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1; s_axi_wready  out  1.
- s_axi_bid  out  ID_W; s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1.
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/LEN_W/3/2  read address channel.
- s_axi_arvalid  in  1; s_axi_arready  out  1.
- s_axi_rid  out  ID_W; s_axi_rdata  out  DATA_W; s_axi_rresp  out  2; s_axi_rlast  out  1; s_axi_rvalid  out  1; s_axi_rready  in  1.
- valid  out  1  native request.
- address  out  ADDR_W  native byte address.
- wdata  out  DATA_W; wstrb  out  DATA_W/8  (wstrb all zero means read).
- rdata  in  DATA_W; ready  in  1  native completion.

Behaviour:
- Reset: all s_axi_*ready, bvalid, rvalid, rlast and valid are 0; all data, resp, id, address and wstrb registers are 0; FSM goes to IDLE; write/read priority flag selects write. Reset mid-burst aborts silently and leaves no pending state.
- FSM states: IDLE, WR_BEAT, WR_MEM, WR_RESP, RD_MEM, RD_BEAT.
- IDLE, grant:
  - awready = awvalid && grant_w; arready = arvalid && !grant_w, both combinational in IDLE only.
  - If only one of awvalid/arvalid is high, that channel is granted.
  - If both are high, grant alternates: the channel not served last wins.
- IDLE, handshake: on handshake, latch id, addr, len, size and burst; beat counter = len; error = (burst==WRAP or reserved 2'b11) or (2^size > DATA_W/8). Next state is WR_BEAT or RD_MEM.
- WR_BEAT:
  - wready=1; on wvalid, latch wdata/wstrb, drop wready.
  - wlast must equal (count==0); a mismatch sets error.
  - If error is set, skip the memory access and stay in WR_BEAT/advance as below; otherwise go to WR_MEM.
- WR_MEM:
  - valid=1 with address/wdata/wstrb held stable until ready.
  - On ready: valid=0. If count==0, go to WR_RESP; else advance address, decrement count, return to WR_BEAT.
- WR_RESP: bvalid=1, bid=latched id, bresp=SLVERR(2'b10) if error else OKAY. Hold until bready, then go to IDLE.
- Beat count is authoritative. Exactly len+1 W beats are consumed regardless of wlast.
- RD_MEM:
  - If error: rdata=0 and go to RD_BEAT directly.
  - Else valid=1, wstrb=0; on ready, register rdata into s_axi_rdata and go to RD_BEAT.
- RD_BEAT:
  - rvalid=1, rid=id, rresp=SLVERR/OKAY, rlast=(count==0); all held until rready.
  - On rready: if last, go to IDLE; else advance address, decrement count, go to RD_MEM.
- Address advance:
  - INCR adds 2^size and wraps modulo 2^ADDR_W.
  - FIXED keeps the address.
  - Native address is the AXI address unmodified.
- Latency:
  - Native request is issued 1 cycle after the W handshake.
  - rvalid rises 1 cycle after native ready.
  - Minimum read beat = 2 cycles plus native latency.
- Simultaneous events: a native ready arriving in the same cycle as a new valid is legal (zero-wait memory).

Decomposition:
- Package axi_native_slave_pkg holds:
  - burst codes FIXED=0, INCR=1, WRAP=2;
  - resp codes OKAY=0, SLVERR=2;
  - FSM state encoding.
- Sub-module axi_burst_addr computes the next address from addr, size and burst; it is shared with the DMA masters.

Test Plan:
- Single write: AW addr 0x100, len 0, size 2, INCR, data 0xDEADBEEF, wstrb 0xF -> native write at 0x100, then bresp=0 and bid echoed.
- INCR write: len 3 at 0x200 -> native writes at 0x200, 0x204, 0x208, 0x20C in order, then exactly one B response.
- INCR read: len 3 at 0x200 with rready low for 3 cycles on beat 1 -> data returned in order, rlast only on beat 4, rdata stable while stalled.
- Simultaneous awvalid and arvalid, twice -> write served first, then read; on the next collision the read wins.
- Error cases:
  - WRAP burst, len 1 -> no native write; two W beats accepted; bresp=2'b10.
  - Read with size 3 on DATA_W=32 -> two beats with rresp=2'b10 and rdata=0.
- rst_n low during WR_MEM of beat 2 -> valid, wready and bvalid all 0 immediately; next AW is accepted normally.
